aoi_sweep_ctrl: RTL
===================

Name: aoi_sweep_ctrl

Overview:
- Sequencer that drives the 5-input AOI gate through all 32 input combinations in ascending order.
- For each combination it waits a programmable settle time, then samples the gate output and compares it against a built-in golden AOI function.
- It accumulates a mismatch count and captures the first failing vector.
- It sits between a host start/abort handshake and the AOI datapath, as an on-chip exhaustive self-check.

Parameters:
- SETTLE_CYCLES, default 2: cycles each vector is held before sampling; legal range 1..15.
- CNT_W, default 4: width of the internal settle counter; must hold SETTLE_CYCLES-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- abort  input  1  terminates a sweep in progress; no done pulse is produced.
- y_in  input  1  AOI gate output (y_out of the gate).
- x_out  output  5  vector to the gate; x_out[4]=x_in1, [3]=x_in2, [2]=x_in3, [1]=x_in4, [0]=x_in5.
- busy  output  1  high in APPLY and SAMPLE.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  high when the last completed sweep had zero mismatches; held until the next accepted start.
- err_count  output  6  number of mismatching vectors, 0..32.
- first_fail_vec  output  5  first vector whose sample mismatched.
- first_fail_valid  output  1  first_fail_vec holds a captured value.

Behaviour:
- Golden function: g = ~((x1&x2)|(x3&x4)|x5), evaluated on the registered vector (vec).
- Reset (asynchronous, rst_n=0):
  - state=IDLE; vec, x_out, settle counter, err_count, first_fail_vec = 0.
  - busy, done, pass, first_fail_valid = 0.
  - Reset mid-sweep discards all progress.
- All outputs are registered; x_out always equals vec.
- IDLE:
  - If start=1 at an edge: vec<=0, cnt<=0, err_count<=0, pass<=0, first_fail_valid<=0, state<=APPLY.
  - abort is ignored in IDLE.
- APPLY:
  - cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1, state<=SAMPLE, so APPLY lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle):
  - At the closing edge, compare y_in against g(vec).
  - On mismatch: err_count<=err_count+1. If first_fail_valid=0, also capture first_fail_vec<=vec and set first_fail_valid<=1.
  - If vec==31: state<=DONE.
  - Otherwise: vec<=vec+1, cnt<=0, state<=APPLY.
- DONE (one cycle):
  - done=1; pass<=(err_count==0); state<=IDLE. x_out keeps 5'b11111 until the next start.
- Timing:
  - Vector period is SETTLE_CYCLES+1 cycles.
  - If start is accepted at edge k, done is high during the cycle following edge k+32*(SETTLE_CYCLES+1).
  - With SETTLE_CYCLES=2 that is edge k+96.
- abort=1 in APPLY or SAMPLE:
  - Next state IDLE; vec and x_out cleared to 0; err_count and first_fail fields frozen; no done pulse; pass stays 0.
  - abort has priority over the sample comparison in the same cycle.
- start while busy is ignored. start and abort are never both acted on in one cycle: in IDLE start wins, otherwise abort wins.
- err_count never wraps; its maximum of 32 fits in 6 bits.

Optional Feature:
- AOI_STOP_ON_FAIL_EN defined:
  - The first mismatch in SAMPLE sends state directly to DONE, with err_count=1 and first_fail captured.
  - done pulses the following cycle and pass=0.
- Not defined: the full 32-vector sweep always runs as described above.

Test Plan:
- Reset with start=0 -> x_out=0, busy=0, done=0, pass=0, err_count=0, first_fail_valid=0.
- y_in driven by a correct AOI model, SETTLE_CYCLES=2, start at edge k -> busy high for 96 cycles; x_out steps 0..31 every 3 cycles; done pulse after edge k+96; pass=1, err_count=0, first_fail_valid=0.
- y_in stuck at 0 -> err_count=9, first_fail_vec=5'b00000, first_fail_valid=1, pass=0. (With AOI_STOP_ON_FAIL_EN: done after edge k+3, err_count=1.)
- y_in stuck at 1 -> err_count=23, first_fail_vec=5'b00001, pass=0. (With AOI_STOP_ON_FAIL_EN: done after edge k+6.)
- abort while x_out=10 -> IDLE next edge, x_out=0, busy=0, no done pulse; a following start completes a normal sweep with pass=1 against the correct model.
- start pulsed while busy at vector 5 -> sweep continues undisturbed. rst_n low at vector 20 -> all outputs immediately 0 and state IDLE.

Source files
------------

// File: rtl/aoi_sweep_ctrl_if.sv
// Host/gate signal bundle for aoi_sweep_ctrl: start/abort request side,
// status/result side, the AOI vector out and the sampled gate output in.
interface aoi_sweep_ctrl_if;
   logic       start;
   logic       abort;
   logic       y_in;
   logic [4:0] x_out;
   logic       busy;
   logic       done;
   logic       pass;
   logic [5:0] err_count;
   logic [4:0] first_fail_vec;
   logic       first_fail_valid;
   logic [1:0] state_dbg;

   modport master (
      output start, abort, y_in,
      input  x_out, busy, done, pass, err_count, first_fail_vec, first_fail_valid, state_dbg
   );

   modport slave (
      input  start, abort, y_in,
      output x_out, busy, done, pass, err_count, first_fail_vec, first_fail_valid, state_dbg
   );
endinterface

// File: rtl/aoi_sweep_ctrl.sv
// Exhaustive self-check sequencer for the 5-input AOI gate: sweeps all 32 vectors,
// compares against g = ~((x1&x2)|(x3&x4)|x5). Optional macro: AOI_STOP_ON_FAIL_EN.
module aoi_sweep_ctrl #(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 4
) (
   input logic             clk,
   input logic             rst_n,
   aoi_sweep_ctrl_if.slave bus
);
   // Handshake: start is a one-cycle request sampled only in IDLE (start wins there);
   // abort is level-sampled in APPLY/SAMPLE and beats the sample comparison; done is a
   // one-cycle pulse and never follows an abort; busy covers APPLY and SAMPLE.
   typedef enum logic [1:0] {IDLE = 2'd0, APPLY = 2'd1, SAMPLE = 2'd2, DONE = 2'd3} state_t;

   state_t           state, state_nx;
   logic [4:0]       vec, vec_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [5:0]       err_count, err_nx;
   logic [4:0]       ff_vec, ff_vec_nx;
   logic             ff_valid, ff_valid_nx;
   logic             pass, pass_nx;
   logic             busy_q, done_q;
   logic             golden, mismatch;

   assign golden   = ~((vec[4] & vec[3]) | (vec[2] & vec[1]) | vec[0]);
   assign mismatch = (bus.y_in != golden);

   always_comb begin
      state_nx    = state;
      vec_nx      = vec;
      cnt_nx      = cnt;
      err_nx      = err_count;
      ff_vec_nx   = ff_vec;
      ff_valid_nx = ff_valid;
      pass_nx     = pass;
      case (state)
         IDLE: begin
            if (bus.start) begin
               vec_nx      = 5'd0;
               cnt_nx      = '0;
               err_nx      = 6'd0;
               pass_nx     = 1'b0;
               ff_valid_nx = 1'b0;
               state_nx    = APPLY;
            end
         end
         APPLY: begin
            if (bus.abort) begin
               vec_nx   = 5'd0;
               cnt_nx   = '0;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
               if (cnt == CNT_W'(SETTLE_CYCLES - 1))
                  state_nx = SAMPLE;
            end
         end
         SAMPLE: begin
            if (bus.abort) begin
               vec_nx   = 5'd0;
               cnt_nx   = '0;
               state_nx = IDLE;
            end else begin
               if (mismatch) begin
                  err_nx = err_count + 6'd1;
                  if (!ff_valid) begin
                     ff_vec_nx   = vec;
                     ff_valid_nx = 1'b1;
                  end
               end
`ifdef AOI_STOP_ON_FAIL_EN
               if (mismatch || vec == 5'd31) begin
                  state_nx = DONE;
               end else begin
                  vec_nx   = vec + 5'd1;
                  cnt_nx   = '0;
                  state_nx = APPLY;
               end
`else
               if (vec == 5'd31) begin
                  state_nx = DONE;
               end else begin
                  vec_nx   = vec + 5'd1;
                  cnt_nx   = '0;
                  state_nx = APPLY;
               end
`endif
            end
         end
         DONE: begin
            pass_nx  = (err_count == 6'd0);
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         vec       <= 5'd0;
         cnt       <= '0;
         err_count <= 6'd0;
         ff_vec    <= 5'd0;
         ff_valid  <= 1'b0;
         pass      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_nx;
         vec       <= vec_nx;
         cnt       <= cnt_nx;
         err_count <= err_nx;
         ff_vec    <= ff_vec_nx;
         ff_valid  <= ff_valid_nx;
         pass      <= pass_nx;
         busy_q    <= (state_nx == APPLY) || (state_nx == SAMPLE);
         done_q    <= (state_nx == DONE);
      end
   end

   assign bus.x_out            = vec;
   assign bus.busy             = busy_q;
   assign bus.done             = done_q;
   assign bus.pass             = pass;
   assign bus.err_count        = err_count;
   assign bus.first_fail_vec   = ff_vec;
   assign bus.first_fail_valid = ff_valid;
   assign bus.state_dbg        = state;
endmodule
